// File: rtl/msi001_cfg_seq_if.sv
// Host-side table/control bus plus SPI-master hookup for the MSI001 config sequencer.
// The slave modport is the sequencer; the master modport is whatever drives it (host + SPI master).
interface msi001_cfg_seq_if #(
    parameter int NUM_WORDS = 8
);
    localparam int AW = $clog2(NUM_WORDS);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          start;
    logic [AW:0]   seq_len;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] word_idx;
    logic [23:0]   spi_data;
    logic          spi_restart;
    logic          spi_complete;

    modport master (
        output wr_en, wr_addr, wr_data, start, seq_len, spi_complete,
        input  busy, done, error, word_idx, spi_data, spi_restart
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, seq_len, spi_complete,
        output busy, done, error, word_idx, spi_data, spi_restart
    );
endinterface

// File: rtl/msi001_cfg_seq.sv
// Plays a writable table of 24-bit MSI001 register words out to the SPI master, one word per
// restart/transfer/gap cycle, waiting on the master's completion edge with a per-word timeout.
module msi001_cfg_seq #(
    parameter int NUM_WORDS      = 8,
    parameter int RESTART_CYCLES = 8,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    msi001_cfg_seq_if.slave         bus
);
    localparam int AW     = $clog2(NUM_WORDS);
    localparam int MAX_RG = (RESTART_CYCLES > GAP_CYCLES) ? RESTART_CYCLES : GAP_CYCLES;
    localparam int MAXC   = (TIMEOUT_CYCLES > MAX_RG) ? TIMEOUT_CYCLES : MAX_RG;
    localparam int CW     = $clog2(MAXC + 1);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_RST  = CW'(RESTART_CYCLES - 1);
    localparam logic [CW-1:0] CNT_GAP  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_TMO  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    localparam logic [AW-1:0] IDX_LAST = AW'(NUM_WORDS - 1);
    localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LEN_MAX  = (AW+1)'(NUM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESTART,
        S_WAIT,
        S_GAP,
        S_FINISH
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [23:0]   r_table [NUM_WORDS];
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] r_last;
    logic [23:0]   r_spi_data;
    logic          r_busy;
    logic          r_error;
    logic          r_spi_restart;
    logic          r_cmpl_q;

    logic          w_accept;
    logic          w_first;
    logic          w_advance;
    logic          w_timeout;
    logic          w_rise;
    logic [AW-1:0] w_len_last;
    logic [AW-1:0] w_idx_inc;

    assign w_rise     = bus.spi_complete & ~r_cmpl_q;
    assign w_idx_inc  = r_idx + IDX_ONE;
    // Over-long requests are clamped to the table depth.
    assign w_len_last = (bus.seq_len > LEN_MAX) ? IDX_LAST : AW'(bus.seq_len - LEN_ONE);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_ONE;
        w_accept    = 1'b0;
        w_first     = 1'b0;
        w_advance   = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (bus.start) begin
                    w_accept = 1'b1;
                    if (bus.seq_len == '0) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_first     = 1'b1;
                        w_state_nxt = S_RESTART;
                    end
                end
            end
            S_RESTART: begin
                if (r_cnt == CNT_RST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_rise) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else if (r_cnt == CNT_TMO) begin
                    w_cnt_nxt   = '0;
                    w_timeout   = 1'b1;
                    w_state_nxt = S_FINISH;
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_GAP) begin
                    w_cnt_nxt = '0;
                    if (r_idx == r_last) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_advance   = 1'b1;
                        w_state_nxt = S_RESTART;
                    end
                end
            end
            S_FINISH: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_last        <= '0;
            r_spi_data    <= '0;
            r_busy        <= 1'b0;
            r_error       <= 1'b0;
            r_spi_restart <= 1'b1;
            r_cmpl_q      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_cmpl_q      <= bus.spi_complete;
            r_spi_restart <= (w_state_nxt != S_WAIT);
            if (w_accept) begin
                r_error <= 1'b0;
                r_idx   <= '0;
                r_last  <= w_len_last;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
            // A table write coinciding with start must reach the first word.
            if (w_first) begin
                r_busy     <= 1'b1;
                r_spi_data <= (bus.wr_en && bus.wr_addr == '0) ? bus.wr_data : r_table[0];
            end
            if (w_advance) begin
                r_idx      <= w_idx_inc;
                r_spi_data <= r_table[w_idx_inc];
            end
            if (r_state == S_FINISH) begin
                r_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_table[i] <= '0;
            end
        end else if (bus.wr_en && r_state == S_IDLE) begin
            r_table[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = (r_state == S_FINISH);
    assign bus.error       = r_error;
    assign bus.word_idx    = r_idx;
    assign bus.spi_data    = r_spi_data;
    assign bus.spi_restart = r_spi_restart;
endmodule
